mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares one single-port unified memory between the processor's instruction-fetch
//   port and its load/store port. Arbitrates per access, drives the memory command, and
//   steers read data back to the requester. Sits between the arm core and a unified
//   memory, replacing the separate imem/dmem pair.
//   Data port has priority; a starvation guard bounds the fetch wait.
// PARAMETERS
//   RD_LATENCY    2  cycles from m_en (read) to valid m_rdata; legal range >= 1
//   STARVE_LIMIT  4  consecutive data grants lost by a pending fetch before fetch is forced to win; >= 1
// PORTS
//   clk       in   1   clock, all state updates on rising edge
//   reset     in   1   synchronous, active-high
//   i_req     in   1   fetch request; held with i_addr until i_gnt
//   i_addr    in   32  fetch address
//   i_gnt     out  1   fetch command accepted this cycle
//   i_rvalid  out  1   one-cycle pulse: i_rdata valid
//   i_rdata   out  32  fetch read data
//   d_req     in   1   data request; held with d_we/d_addr/d_wdata/d_be until d_gnt
//   d_we      in   1   1 = write, 0 = read
//   d_addr    in   32  data address
//   d_wdata   in   32  write data
//   d_be      in   4   byte enables for writes
//   d_gnt     out  1   data command accepted this cycle
//   d_rvalid  out  1   one-cycle pulse: d_rdata valid (reads only)
//   d_rdata   out  32  data read data
//   m_en      out  1   memory command valid
//   m_we      out  1   memory write strobe
//   m_addr    out  32  memory address
//   m_wdata   out  32  memory write data
//   m_be      out  4   memory byte enables
//   m_rdata   in   32  memory read data, valid RD_LATENCY cycles after read m_en
// BEHAVIOUR
//   Reset: state IDLE, latency counter 0, starve counter 0, owner cleared; i_gnt, d_gnt,
//     i_rvalid, d_rvalid, m_en, m_we = 0; i_rdata, d_rdata, m_addr, m_wdata, m_be = 0.
//   FSM: IDLE, BUSY. Only one read outstanding.
//   IDLE arbitration (combinational, same-cycle grant):
//     - starve counter == STARVE_LIMIT and i_req -> grant fetch.
//     - else d_req -> grant data; else i_req -> grant fetch; else no grant.
//     - at most one gnt high per cycle; no grant in BUSY.
//   m_* are a combinational mux of the granted command; no grant -> m_en=m_we=0, m_addr/m_wdata/m_be=0.
//     Fetch command: m_we=0, m_be=4'b1111, m_wdata=0.
//   Data write grant: m_en=1, m_we=1, m_be=d_be; completes in that cycle; no rvalid; stay IDLE,
//     next arbitration the following cycle.
//   Read grant (either port): register owner, load counter with RD_LATENCY, go BUSY.
//   BUSY: decrement counter each cycle; in the cycle the count expires (RD_LATENCY cycles
//     after grant) pulse owner's rvalid, capture m_rdata into owner's rdata, go IDLE.
//     No grant in that cycle; earliest next grant is the following cycle.
//   i_rdata/d_rdata hold last returned value until the next return to that port.
//   Starve counter, updated at each data grant: +1 if i_req was high (saturate at STARVE_LIMIT);
//     cleared on any fetch grant, or on a data grant with i_req low.
//   Reset mid-read (in BUSY): in-flight read dropped, no rvalid pulse, all state to reset values.
//   Addresses passed unmodified (no alignment checks); byte-lane extraction is the core's job.
// TESTING
//   Reset 2 cycles with i_req=d_req=1 -> all gnt/rvalid/m_en 0 throughout; first grant (d) on
//     the first cycle after reset deasserts.
//   Lone fetch 0x00000010, memory returns 0xE3A00005 -> i_gnt and m_en cycle 0, i_rvalid at
//     cycle 2 with i_rdata=0xE3A00005; d_gnt/d_rvalid stay 0.
//   i_req and d_req read 0x64 same cycle -> d_gnt cycle 0, d_rvalid cycle 2, i_gnt cycle 3,
//     i_rvalid cycle 5.
//   Data write 0xDEADBEEF to 0x64, d_be=4'b0011 -> d_gnt cycle 0 with m_we=1, m_be=0011,
//     m_wdata=0xDEADBEEF; no d_rvalid; pending fetch granted cycle 1.
//   d_req reads held continuously, i_req held -> d wins grants 1-4, fetch wins grant 5, then
//     data wins again; starve counter back to 0 after fetch grant.
//   Reset asserted 1 cycle after a data read grant -> no d_rvalid ever appears; a fresh fetch
//     after reset returns its own data at RD_LATENCY.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for one single-port unified memory
module mem_arbiter #(
  parameter int RD_LATENCY   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LAT = CW'(RD_LATENCY);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] starve, starve_nxt;
  logic          owner, owner_nxt;  // 1 = data port owns the outstanding read
  logic [31:0]   i_rdata_q, d_rdata_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    starve_nxt = starve;
    owner_nxt  = owner;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    m_en       = 1'b0;
    m_we       = 1'b0;
    m_addr     = 32'h0;
    m_wdata    = 32'h0;
    m_be       = 4'h0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (i_req && (starve == LIM || !d_req)) begin
            i_gnt      = 1'b1;
            m_en       = 1'b1;
            m_addr     = i_addr;
            m_be       = 4'hf;
            starve_nxt = '0;
            owner_nxt  = 1'b0;
            cnt_nxt    = LAT;
            state_nxt  = BUSY;
          end else if (d_req) begin
            d_gnt   = 1'b1;
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_be    = d_be;
            if (!i_req)
              starve_nxt = '0;
            else if (starve != LIM)
              starve_nxt = starve + 1'b1;
            // Writes finish in the grant cycle; only reads occupy the memory.
            if (!d_we) begin
              owner_nxt = 1'b1;
              cnt_nxt   = LAT;
              state_nxt = BUSY;
            end
          end
        end
        BUSY: begin
          cnt_nxt = cnt - 1'b1;
          if (cnt == 1) begin
            i_rvalid  = !owner;
            d_rvalid  = owner;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      starve    <= '0;
      owner     <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      starve <= starve_nxt;
      owner  <= owner_nxt;
      if (i_rvalid) i_rdata_q <= m_rdata;
      if (d_rvalid) d_rdata_q <= m_rdata;
    end
  end

  // Return data is bypassed so it is visible in the rvalid cycle, then held.
  assign i_rdata = i_rvalid ? m_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;
  localparam int RL = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0;
  logic [3:0]  d_be = 4'hf;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  mem_arbiter #(.RD_LATENCY(RL), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory emulator: contents plus a return table indexed by issue cycle.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rtab [16];
  assign m_rdata = rtab[4'((cyc + 16 - RL) % 16)];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A0000;
  endfunction

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", n, cyc, act, exp);
    end
  endtask

  // Model: an outstanding read is just (port, address, due cycle).
  bit          mb = 0;
  bit          mport = 0;
  int          mdue = 0;
  int          mst = 0;
  logic [31:0] maddr = 0, li = 0, ld = 0;

  // Observation log for directed literal checks.
  int          n_ig = 0, n_dg = 0, n_irv = 0, n_drv = 0;
  int          t_ig = -1, t_dg = -1, t_irv = -1, t_drv = -1;
  logic [31:0] v_irv = 0, v_drv = 0, dg_wd = 0;
  logic        dg_we = 0;
  logic [3:0]  dg_be = 0;
  string       gseq = "";

  always @(negedge clk) begin
    logic        ei, ed, eiv, edv, een, ewe;
    logic [31:0] ea, ewd, eir, edr, w;
    logic [3:0]  ebe;
    ei = 0; ed = 0; eiv = 0; edv = 0; een = 0; ewe = 0;
    ea = 0; ewd = 0; ebe = 0; eir = li; edr = ld;
    if (reset) begin
      mb = 0; mst = 0; li = 0; ld = 0;
    end else if (mb) begin
      if (cyc == mdue) begin
        mb = 0;
        if (mport) begin edv = 1; edr = memval(maddr); ld = edr; end
        else       begin eiv = 1; eir = memval(maddr); li = eir; end
      end
    end else if (i_req && (mst == SL || !d_req)) begin
      ei = 1; een = 1; ea = i_addr; ebe = 4'hf;
      mst = 0; mb = 1; mport = 0; maddr = i_addr; mdue = cyc + RL;
    end else if (d_req) begin
      ed = 1; een = 1; ewe = d_we; ea = d_addr; ewd = d_wdata; ebe = d_be;
      mst = i_req ? ((mst < SL) ? mst + 1 : SL) : 0;
      if (!d_we) begin mb = 1; mport = 1; maddr = d_addr; mdue = cyc + RL; end
    end
    chk("i_gnt", 32'(i_gnt), 32'(ei));
    chk("d_gnt", 32'(d_gnt), 32'(ed));
    chk("i_rvalid", 32'(i_rvalid), 32'(eiv));
    chk("d_rvalid", 32'(d_rvalid), 32'(edv));
    chk("m_en", 32'(m_en), 32'(een));
    chk("m_we", 32'(m_we), 32'(ewe));
    chk("m_addr", m_addr, ea);
    chk("m_wdata", m_wdata, ewd);
    chk("m_be", 32'(m_be), 32'(ebe));
    if (!reset) begin
      chk("i_rdata", i_rdata, eir);
      chk("d_rdata", d_rdata, edr);
    end
    rtab[4'(cyc % 16)] = (m_en && !m_we) ? memval(m_addr) : 32'hCCCCCCCC;
    if (m_en && m_we) begin
      w = memval(m_addr);
      for (int b = 0; b < 4; b++) if (m_be[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
      mem[m_addr] = w;
    end
    if (i_gnt) begin n_ig++; if (t_ig < 0) t_ig = cyc; gseq = {gseq, "i"}; end
    if (d_gnt) begin
      n_dg++; gseq = {gseq, "d"};
      if (t_dg < 0) begin t_dg = cyc; dg_we = m_we; dg_be = m_be; dg_wd = m_wdata; end
    end
    if (i_rvalid) begin n_irv++; if (t_irv < 0) begin t_irv = cyc; v_irv = i_rdata; end end
    if (d_rvalid) begin n_drv++; if (t_drv < 0) begin t_drv = cyc; v_drv = d_rdata; end end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mark();
    t_ig = -1; t_dg = -1; t_irv = -1; t_drv = -1; gseq = "";
  endtask

  // Runs n cycles; requests drop after their grant unless kept asserted.
  task automatic run(input int n, input bit keep_i, input bit keep_d);
    logic gi, gd;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      gi = i_gnt; gd = d_gnt;
      @(posedge clk); #1;
      if (gi && !keep_i) i_req = 0;
      if (gd && !keep_d) d_req = 0;
    end
  endtask

  initial begin
    int c0, nd;
    for (int k = 0; k < 16; k++) rtab[k] = 32'hCCCCCCCC;
    mem[32'h10] = 32'hE3A00005;
    i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h64;

    // Reset held with both requests up, then simultaneous requests.
    repeat (3) tick();
    chk("reset_no_grant", 32'(n_ig + n_dg + n_irv + n_drv), 32'd0);
    reset = 0; mark(); c0 = cyc;
    run(8, 0, 0);
    chk("both_dgnt_c0", 32'(t_dg), 32'(c0));
    chk("both_drv_c2", 32'(t_drv), 32'(c0 + 2));
    chk("both_drdata", v_drv, 32'h5A5A0064);
    chk("both_ignt_c3", 32'(t_ig), 32'(c0 + 3));
    chk("both_irv_c5", 32'(t_irv), 32'(c0 + 5));

    // Lone fetch.
    i_req = 1; i_addr = 32'h10; mark(); c0 = cyc;
    run(6, 0, 0);
    chk("fetch_ignt_c0", 32'(t_ig), 32'(c0));
    chk("fetch_irv_c2", 32'(t_irv), 32'(c0 + 2));
    chk("fetch_irdata", v_irv, 32'hE3A00005);
    chk("fetch_no_dgnt", 32'(t_dg), 32'hFFFFFFFF);
    chk("fetch_no_drv", 32'(t_drv), 32'hFFFFFFFF);

    // Partial write with a fetch pending.
    d_req = 1; d_we = 1; d_addr = 32'h64; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    i_req = 1; i_addr = 32'h10; mark(); c0 = cyc;
    run(6, 0, 0);
    chk("wr_dgnt_c0", 32'(t_dg), 32'(c0));
    chk("wr_m_we", 32'(dg_we), 32'd1);
    chk("wr_m_be", 32'(dg_be), 32'h3);
    chk("wr_m_wdata", dg_wd, 32'hDEADBEEF);
    chk("wr_no_drv", 32'(t_drv), 32'hFFFFFFFF);
    chk("wr_ignt_c1", 32'(t_ig), 32'(c0 + 1));
    d_req = 1; d_we = 0; d_be = 4'hf; mark();
    run(5, 0, 0);
    chk("wr_readback", v_drv, 32'h5A5ABEEF);

    // Continuous data reads against a held fetch: starvation guard.
    d_req = 1; d_we = 0; d_addr = 32'h64; i_req = 1; i_addr = 32'h10; mark();
    run(30, 1, 1);
    d_req = 0; i_req = 0;
    run(4, 0, 0);
    total++;
    if (gseq != "ddddiddddi") begin
      bad++;
      $display("FAIL starve_seq actual=%s required=ddddiddddi", gseq);
    end

    // Reset one cycle after a data read grant.
    d_req = 1; d_we = 0; d_addr = 32'h64; mark(); c0 = cyc; nd = n_drv;
    tick();
    d_req = 0; reset = 1;
    tick();
    reset = 0;
    run(5, 0, 0);
    chk("rst_dgnt_c0", 32'(t_dg), 32'(c0));
    chk("rst_no_drv", 32'(n_drv), 32'(nd));
    i_req = 1; i_addr = 32'h20; mark(); c0 = cyc;
    run(5, 0, 0);
    chk("rst_fetch_irv", 32'(t_irv), 32'(c0 + 2));
    chk("rst_fetch_data", v_irv, 32'h5A5A0020);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
